ps2_device: RTL and testbench



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_channel.sv | 216 +++++++++++++++++++++
 rtl/ps2_device.sv | 58 +++++
 tb/tb_ps2_device.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device model: FSM states, frame
// geometry, the auto-acknowledge byte and the microsecond-to-cycle helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_HIGH,
    TX_LOW,
    TX_GAP,
    INHIBIT,
    RX_WAIT,
    RX_HIGH,
    RX_LOW,
    RX_ACK
  } ps2_state_t;

  localparam int         FRAME_LEN = 11;
  localparam logic [7:0] ACK_CODE  = 8'hFA;

  function automatic int tick_count(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_channel.sv
// One PS/2 device-side link: generates the link clock, transmits queued bytes,
// detects host request-to-send and receives host bytes with line ACK.
module ps2_channel
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int HALF_US    = 40,
  parameter int INHIBIT_US = 100,
  parameter int AUTO_ACK   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_clk,
  input  logic       line_dat,
  output logic       drive_clk,
  output logic       drive_dat,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_perr
);

  localparam int             CW        = 24;
  localparam int             H_T       = tick_count(CLK_HZ, HALF_US);
  localparam int             INH_T     = tick_count(CLK_HZ, INHIBIT_US);
  localparam logic [CW-1:0]  H_LAST    = CW'(H_T - 1);
  localparam logic [CW-1:0]  INH_MIN   = CW'(INH_T);
  localparam logic [CW-1:0]  RETRY_MIN = CW'(2 * H_T);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_LEN - 1);

  logic [1:0]    clk_sync_reg, dat_sync_reg;
  logic          clk_s, dat_s;
  ps2_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] high_reg, high_next;
  logic [3:0]    bit_reg, bit_next;
  logic [10:0]   frame_reg, frame_next;
  logic [9:0]    rx_sh_reg, rx_sh_next;
  logic [7:0]    slot_reg, slot_next;
  logic          pend_reg, pend_next;
  logic          ack_reg, ack_next;
  logic          retry_reg, retry_next;
  logic          drive_clk_reg, drive_clk_next;
  logic          drive_dat_reg, drive_dat_next;
  logic          rx_valid_reg, rx_valid_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_perr_reg, rx_perr_next;
  logic          rx_bad;

  assign clk_s     = clk_sync_reg[1];
  assign dat_s     = dat_sync_reg[1];
  assign drive_clk = drive_clk_reg;
  assign drive_dat = drive_dat_reg;
  assign tx_ready  = !pend_reg && !ack_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_data   = rx_data_reg;
  assign rx_perr   = rx_perr_reg;

  // Synchronizers reset to 1 so an idle (pulled-up) line is not mistaken for an inhibit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_reg  <= 2'b11;
      dat_sync_reg  <= 2'b11;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      high_reg      <= '0;
      bit_reg       <= '0;
      frame_reg     <= '0;
      rx_sh_reg     <= '0;
      slot_reg      <= '0;
      pend_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      retry_reg     <= 1'b0;
      drive_clk_reg <= 1'b0;
      drive_dat_reg <= 1'b0;
      rx_valid_reg  <= 1'b0;
      rx_data_reg   <= '0;
      rx_perr_reg   <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], line_clk};
      dat_sync_reg  <= {dat_sync_reg[0], line_dat};
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      high_reg      <= high_next;
      bit_reg       <= bit_next;
      frame_reg     <= frame_next;
      rx_sh_reg     <= rx_sh_next;
      slot_reg      <= slot_next;
      pend_reg      <= pend_next;
      ack_reg       <= ack_next;
      retry_reg     <= retry_next;
      drive_clk_reg <= drive_clk_next;
      drive_dat_reg <= drive_dat_next;
      rx_valid_reg  <= rx_valid_next;
      rx_data_reg   <= rx_data_next;
      rx_perr_reg   <= rx_perr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 24'd1;
    high_next      = clk_s ? ((high_reg == RETRY_MIN) ? high_reg : high_reg + 24'd1) : '0;
    bit_next       = bit_reg;
    frame_next     = frame_reg;
    rx_sh_next     = rx_sh_reg;
    slot_next      = slot_reg;
    pend_next      = pend_reg;
    ack_next       = ack_reg;
    retry_next     = retry_reg;
    drive_clk_next = drive_clk_reg;
    drive_dat_next = drive_dat_reg;
    rx_valid_next  = 1'b0;
    rx_data_next   = rx_data_reg;
    rx_perr_next   = rx_perr_reg;
    rx_bad         = !(^rx_sh_reg[8:0]) || !rx_sh_reg[9];

    // The single byte slot: a pending auto-ACK is loaded ahead of new stimulus.
    if (!pend_reg) begin
      if (ack_reg) begin
        slot_next = ACK_CODE;
        pend_next = 1'b1;
        ack_next  = 1'b0;
      end else if (tx_valid) begin
        slot_next = tx_data;
        pend_next = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (!clk_s) begin
          state_next = INHIBIT;
        end else if (pend_reg && (!retry_reg || high_reg == RETRY_MIN)) begin
          frame_next     = {1'b1, ~^slot_reg, slot_reg, 1'b0};
          drive_dat_next = 1'b1;
          drive_clk_next = 1'b0;
          retry_next     = 1'b0;
          state_next     = TX_HIGH;
        end
      end
      TX_HIGH: if (cnt_reg == H_LAST) begin
        cnt_next = '0;
        if (!clk_s) begin
          // Host is holding the clock: drop the frame but keep the byte.
          drive_clk_next = 1'b0;
          drive_dat_next = 1'b0;
          retry_next     = 1'b1;
          state_next     = IDLE;
        end else begin
          drive_clk_next = 1'b1;
          state_next     = TX_LOW;
        end
      end
      TX_LOW: if (cnt_reg == H_LAST) begin
        cnt_next       = '0;
        drive_clk_next = 1'b0;
        if (bit_reg == LAST_BIT) begin
          drive_dat_next = 1'b0;
          state_next     = TX_GAP;
        end else begin
          bit_next       = bit_reg + 4'd1;
          frame_next     = {1'b1, frame_reg[10:1]};
          drive_dat_next = ~frame_reg[1];
          state_next     = TX_HIGH;
        end
      end
      TX_GAP: if (cnt_reg == H_LAST) begin
        pend_next  = 1'b0;
        state_next = IDLE;
      end
      INHIBIT: begin
        if (clk_s) begin
          cnt_next   = '0;
          state_next = (cnt_reg == INH_MIN && !dat_s) ? RX_WAIT : IDLE;
        end else if (cnt_reg == INH_MIN) begin
          cnt_next = cnt_reg;
        end
      end
      RX_WAIT: if (cnt_reg == H_LAST) begin
        cnt_next       = '0;
        drive_clk_next = 1'b1;
        state_next     = RX_LOW;
      end
      RX_LOW: if (cnt_reg == H_LAST) begin
        // Releasing the clock here is the rising edge the host's bit is sampled on.
        cnt_next       = '0;
        drive_clk_next = 1'b0;
        rx_sh_next     = {dat_s, rx_sh_reg[9:1]};
        bit_next       = bit_reg + 4'd1;
        if (bit_reg == 4'd9) drive_dat_next = 1'b1;
        state_next     = RX_HIGH;
      end
      RX_HIGH: if (cnt_reg == H_LAST) begin
        cnt_next       = '0;
        drive_clk_next = 1'b1;
        state_next     = (bit_reg == 4'd10) ? RX_ACK : RX_LOW;
      end
      RX_ACK: if (cnt_reg == H_LAST) begin
        drive_clk_next = 1'b0;
        drive_dat_next = 1'b0;
        rx_valid_next  = 1'b1;
        rx_data_next   = rx_sh_reg[7:0];
        rx_perr_next   = rx_bad;
        if (AUTO_ACK != 0 && !rx_bad) ack_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_device.sv
// Device-side model of the RISC5 keyboard and mouse PS/2 links: two independent
// channels driving open-drain pins (0 or released).
module ps2_device
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int HALF_US    = 40,
  parameter int INHIBIT_US = 100,
  parameter int AUTO_ACK   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        PS2C,
  inout  wire        PS2D,
  inout  wire        msclk,
  inout  wire        msdat,
  input  logic       kb_tx_valid,
  input  logic [7:0] kb_tx_data,
  output logic       kb_tx_ready,
  input  logic       ms_tx_valid,
  input  logic [7:0] ms_tx_data,
  output logic       ms_tx_ready,
  output logic       kb_rx_valid,
  output logic [7:0] kb_rx_data,
  output logic       kb_rx_perr,
  output logic       ms_rx_valid,
  output logic [7:0] ms_rx_data,
  output logic       ms_rx_perr
);

  logic kb_drive_clk, kb_drive_dat, ms_drive_clk, ms_drive_dat;

  assign PS2C  = kb_drive_clk ? 1'b0 : 1'bz;
  assign PS2D  = kb_drive_dat ? 1'b0 : 1'bz;
  assign msclk = ms_drive_clk ? 1'b0 : 1'bz;
  assign msdat = ms_drive_dat ? 1'b0 : 1'bz;

  ps2_channel #(
    .CLK_HZ(CLK_HZ), .HALF_US(HALF_US), .INHIBIT_US(INHIBIT_US), .AUTO_ACK(AUTO_ACK)
  ) u_kb (
    .clk(clk), .rst_n(rst_n),
    .line_clk(PS2C), .line_dat(PS2D),
    .drive_clk(kb_drive_clk), .drive_dat(kb_drive_dat),
    .tx_valid(kb_tx_valid), .tx_data(kb_tx_data), .tx_ready(kb_tx_ready),
    .rx_valid(kb_rx_valid), .rx_data(kb_rx_data), .rx_perr(kb_rx_perr)
  );

  ps2_channel #(
    .CLK_HZ(CLK_HZ), .HALF_US(HALF_US), .INHIBIT_US(INHIBIT_US), .AUTO_ACK(AUTO_ACK)
  ) u_ms (
    .clk(clk), .rst_n(rst_n),
    .line_clk(msclk), .line_dat(msdat),
    .drive_clk(ms_drive_clk), .drive_dat(ms_drive_dat),
    .tx_valid(ms_tx_valid), .tx_data(ms_tx_data), .tx_ready(ms_tx_ready),
    .rx_valid(ms_rx_valid), .rx_data(ms_rx_data), .rx_perr(ms_rx_perr)
  );

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: plays the host side of both links with pull-ups and
// checks frames, receive path, inhibit/retry and async reset against a byte-level model.
module tb_ps2_device;

  localparam int CLK_HZ     = 1000000;
  localparam int HALF_US    = 40;
  localparam int INHIBIT_US = 100;
  localparam int H          = (CLK_HZ / 1000000) * HALF_US;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire PS2C, PS2D, msclk, msdat;
  logic h_kb_clk_low = 1'b0, h_kb_dat_low = 1'b0, h_ms_clk_low = 1'b0, h_ms_dat_low = 1'b0;
  assign PS2C  = h_kb_clk_low ? 1'b0 : 1'bz;
  assign PS2D  = h_kb_dat_low ? 1'b0 : 1'bz;
  assign msclk = h_ms_clk_low ? 1'b0 : 1'bz;
  assign msdat = h_ms_dat_low ? 1'b0 : 1'bz;
  pullup (PS2C);
  pullup (PS2D);
  pullup (msclk);
  pullup (msdat);

  logic       kb_tx_valid = 1'b0, ms_tx_valid = 1'b0;
  logic [7:0] kb_tx_data = 8'h00, ms_tx_data = 8'h00;
  logic       kb_tx_ready, ms_tx_ready;
  logic       kb_rx_valid, kb_rx_perr, ms_rx_valid, ms_rx_perr;
  logic [7:0] kb_rx_data, ms_rx_data;

  ps2_device #(.CLK_HZ(CLK_HZ), .HALF_US(HALF_US), .INHIBIT_US(INHIBIT_US), .AUTO_ACK(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .PS2C(PS2C), .PS2D(PS2D), .msclk(msclk), .msdat(msdat),
    .kb_tx_valid(kb_tx_valid), .kb_tx_data(kb_tx_data), .kb_tx_ready(kb_tx_ready),
    .ms_tx_valid(ms_tx_valid), .ms_tx_data(ms_tx_data), .ms_tx_ready(ms_tx_ready),
    .kb_rx_valid(kb_rx_valid), .kb_rx_data(kb_rx_data), .kb_rx_perr(kb_rx_perr),
    .ms_rx_valid(ms_rx_valid), .ms_rx_data(ms_rx_data), .ms_rx_perr(ms_rx_perr)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_fall = 0;
  int last_fall = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Model: odd parity bit is 1 exactly when the data has an even number of ones.
  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = odd_par(d);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic ln_clk(input bit ms); return ms ? msclk : PS2C; endfunction
  function automatic logic ln_dat(input bit ms); return ms ? msdat : PS2D; endfunction
  function automatic logic rdy(input bit ms); return ms ? ms_tx_ready : kb_tx_ready; endfunction

  task automatic host_clk(input bit ms, input logic v);
    if (ms) h_ms_clk_low = v; else h_kb_clk_low = v;
  endtask
  task automatic host_dat(input bit ms, input logic v);
    if (ms) h_ms_dat_low = v; else h_kb_dat_low = v;
  endtask

  task automatic wait_fall(input bit ms, input int budget, output logic dv, output bit ok);
    logic prev, cur;
    ok = 1'b0;
    dv = 1'b0;
    prev = ln_clk(ms);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cur = ln_clk(ms);
      if (prev === 1'b1 && cur === 1'b0) begin
        dv = ln_dat(ms);
        ok = 1'b1;
        return;
      end
      prev = cur;
    end
  endtask

  task automatic send_byte(input bit ms, input logic [7:0] d);
    @(negedge clk);
    check("ready before send", 32'(rdy(ms)), 1);
    if (ms) begin ms_tx_valid = 1'b1; ms_tx_data = d; end
    else begin kb_tx_valid = 1'b1; kb_tx_data = d; end
    @(negedge clk);
    kb_tx_valid = 1'b0;
    ms_tx_valid = 1'b0;
    check("ready drops after accept", 32'(rdy(ms)), 0);
  endtask

  task automatic capture_frame(input bit ms, input logic [7:0] d);
    logic [10:0] got;
    logic dv;
    bit ok;
    int t_prev = 0;
    int spacing_bad = 0;
    int ready_high = 0;
    got = '0;
    for (int i = 0; i < 11; i++) begin
      wait_fall(ms, 6 * H, dv, ok);
      if (!ok) begin
        check("frame falling-edge timeout", 0, 1);
        return;
      end
      got[i] = dv;
      if (i == 0) first_fall = cyc;
      if (i > 0 && (cyc - t_prev) != 2 * H) spacing_bad++;
      if (rdy(ms)) ready_high++;
      t_prev = cyc;
    end
    last_fall = cyc;
    check($sformatf("frame bits ms=%0d byte=%02h", ms, d), 32'(got), 32'(model_frame(d)));
    check("fall spacing 2H", spacing_bad, 0);
    check("ready low during frame", ready_high, 0);
    $display("tx ms=%0d byte=%02h bits=%011b", ms, d, got);
  endtask

  task automatic wait_ready(input bit ms);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * H && !seen; i++) begin
      @(negedge clk);
      if (rdy(ms)) seen = 1'b1;
    end
    check("ready returns after frame", 32'(seen), 1);
  endtask

  task automatic expect_quiet(input bit ms, input string tag);
    logic dv;
    bit ok;
    wait_fall(ms, 6 * H, dv, ok);
    check(tag, 32'(ok), 0);
  endtask

  task automatic host_send(input bit ms, input logic [7:0] d, input bit bad);
    logic [9:0] b;
    logic dv;
    bit ok;
    bit seen = 1'b0;
    b = {1'b1, odd_par(d) ^ bad, d};
    host_clk(ms, 1'b1);
    repeat (150) @(negedge clk);
    host_dat(ms, 1'b1);
    @(negedge clk);
    host_clk(ms, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wait_fall(ms, 4 * H, dv, ok);
      if (!ok) begin
        check("host rx clock timeout", 0, 1);
        host_dat(ms, 1'b0);
        return;
      end
      repeat (5) @(negedge clk);
      host_dat(ms, ~b[i]);
    end
    wait_fall(ms, 4 * H, dv, ok);
    check("11th clock present", 32'(ok), 1);
    check("ACK data low on 11th clock", 32'(dv), 0);
    for (int i = 0; i < 3 * H && !seen; i++) begin
      @(negedge clk);
      if (ms ? ms_rx_valid : kb_rx_valid) begin
        seen = 1'b1;
        check("rx_data", 32'(ms ? ms_rx_data : kb_rx_data), 32'(d));
        check("rx_perr", 32'(ms ? ms_rx_perr : kb_rx_perr), 32'(bad));
      end
    end
    check("rx_valid pulse seen", 32'(seen), 1);
    @(negedge clk);
    check("rx_valid one cycle", 32'(ms ? ms_rx_valid : kb_rx_valid), 0);
    $display("rx ms=%0d byte=%02h bad_parity=%0d", ms, d, bad);
    if (!bad) capture_frame(ms, 8'hFA);
    else expect_quiet(ms, "no reply after parity error");
  endtask

  initial begin
    logic [7:0] rb;
    bit rms;
    logic dv;
    bit ok;
    int t_rel;
    int prev_last;

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset kb_tx_ready", 32'(kb_tx_ready), 1);
    check("reset ms_tx_ready", 32'(ms_tx_ready), 1);
    check("reset rx_valid", 32'({kb_rx_valid, ms_rx_valid}), 0);
    check("reset rx_perr", 32'({kb_rx_perr, ms_rx_perr}), 0);
    check("reset rx_data", 32'({kb_rx_data, ms_rx_data}), 0);
    check("reset lines released", 32'({PS2C, PS2D, msclk, msdat}), 32'hF);

    // Directed 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1 on successive falling edges.
    send_byte(1'b0, 8'h1C);
    capture_frame(1'b0, 8'h1C);
    check("0x1C literal bits", 32'(model_frame(8'h1C)), 32'h438);
    wait_ready(1'b0);

    send_byte(1'b0, 8'hF0);
    capture_frame(1'b0, 8'hF0);
    prev_last = last_fall;
    wait_ready(1'b0);
    send_byte(1'b0, 8'h1C);
    capture_frame(1'b0, 8'h1C);
    check("inter-frame gap >= 3H", 32'((first_fall - prev_last) >= 3 * H), 1);
    wait_ready(1'b0);

    for (int k = 0; k < 3; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rms = 1'($urandom_range(0, 1));
      send_byte(rms, rb);
      capture_frame(rms, rb);
      wait_ready(rms);
    end

    host_send(1'b1, 8'hF4, 1'b0);
    wait_ready(1'b1);
    host_send(1'b1, 8'hF4, 1'b1);
    rb = 8'($urandom_range(0, 255));
    host_send(1'b0, rb, 1'b0);
    wait_ready(1'b0);

    // Short clock-low pulse with data low must not start a receive.
    host_dat(1'b0, 1'b1);
    host_clk(1'b0, 1'b1);
    repeat (50) @(negedge clk);
    host_clk(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    host_dat(1'b0, 1'b0);
    expect_quiet(1'b0, "short inhibit ignored");
    check("short inhibit no rx_valid", 32'(kb_rx_valid), 0);

    // Inhibit after 4 bits of 0xAA, then the frame is resent from the start bit.
    send_byte(1'b0, 8'hAA);
    for (int i = 0; i < 4; i++) wait_fall(1'b0, 6 * H, dv, ok);
    check("4 bits before inhibit", 32'(ok), 1);
    for (int i = 0; i < 2 * H && PS2C !== 1'b1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    host_clk(1'b0, 1'b1);
    repeat (60) @(negedge clk);
    check("data released on abort", 32'(PS2D), 1);
    check("byte held during inhibit", 32'(kb_tx_ready), 0);
    host_clk(1'b0, 1'b0);
    t_rel = cyc;
    capture_frame(1'b0, 8'hAA);
    check("retry waits 2H of clock high", 32'((first_fall - t_rel) >= 2 * H), 1);
    wait_ready(1'b0);

    // Async reset mid-frame with both links driving low.
    @(negedge clk);
    kb_tx_valid = 1'b1; kb_tx_data = 8'h00;
    ms_tx_valid = 1'b1; ms_tx_data = 8'h00;
    @(negedge clk);
    kb_tx_valid = 1'b0; ms_tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) wait_fall(1'b0, 6 * H, dv, ok);
    repeat (5) @(negedge clk);
    check("lines driven before reset", 32'({PS2C, PS2D, msclk, msdat}), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("lines released by async reset", 32'({PS2C, PS2D, msclk, msdat}), 32'hF);
    check("ready during reset", 32'({kb_tx_ready, ms_tx_ready}), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(1'b0, "in-flight byte lost after reset");
    check("ready after reset", 32'({kb_tx_ready, ms_tx_ready}), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
